// File: rtl/ram_arbiter_pkg.sv
// Purpose: shared types and constants for the two-port RAM arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package ram_arbiter_pkg;

    // Arbiter FSM encoding: free arbitration, or burst-locked to requester 0/1
    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_t;

    // Requester indices into the rq_* vectors
    localparam int REQ_CORE   = 0;   // core data port
    localparam int REQ_LOADER = 1;   // loader/debug port

    // Default geometry and burst limit
    localparam int DEF_AW       = 13;
    localparam int DEF_MAX_LOCK = 16;

    // Index of the requester that is not idx
    function automatic logic other_req(input logic idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Purpose: requester-side and RAM-side signal bundle of the arbiter.
// Latency: none (wiring only).
// Backpressure: requesters hold req/addr/data until they see gnt.
interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int AW = DEF_AW
);
    // Requester side
    logic [1:0]    rq_req;
    logic [1:0]    rq_lock;
    logic [3:0]    rq_we0;
    logic [3:0]    rq_we1;
    logic [AW-1:0] rq_addr0;
    logic [AW-1:0] rq_addr1;
    logic [31:0]   rq_wdata0;
    logic [31:0]   rq_wdata1;
    logic [1:0]    rq_gnt;
    logic [1:0]    rq_rvalid;
    logic [31:0]   rq_rdata;

    // RAM side
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    // Environment view: requesters plus the RAM macro
    modport master (
        output rq_req, rq_lock, rq_we0, rq_we1, rq_addr0, rq_addr1,
               rq_wdata0, rq_wdata1, ram_rdata,
        input  rq_gnt, rq_rvalid, rq_rdata, ram_en, ram_we, ram_addr,
               ram_wdata
    );

    // Arbiter view
    modport slave (
        input  rq_req, rq_lock, rq_we0, rq_we1, rq_addr0, rq_addr1,
               rq_wdata0, rq_wdata1, ram_rdata,
        output rq_gnt, rq_rvalid, rq_rdata, ram_en, ram_we, ram_addr,
               ram_wdata
    );

endinterface

// File: rtl/rr_pick2.sv
// Purpose: two-way round-robin pick; the pointer breaks ties only.
// Latency: combinational.
// Backpressure: none; a sole requester always wins.
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_gnt
);

    // One-hot pick: sole requester wins, on contention the pointer decides
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = i_ptr ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Purpose: arbitrates two requesters onto one single-port RAM, with burst lock.
// Latency: grant and RAM drive same cycle; read data/rvalid one cycle later.
// Backpressure: a requester waits with req high until gnt; locks are capped at MAX_LOCK.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic          clk,
    input  logic          resetn,
    ram_arbiter_if.slave  bus
);

    localparam int            CW      = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LOCK);
    // With a limit of one there is nothing to hold, so lock is never entered
    localparam bit            LOCK_EN = (MAX_LOCK > 1);

    arb_state_t    r_state;
    logic          r_ptr;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_rvalid;

    logic [1:0]    w_pick;
    logic [1:0]    w_gnt;
    logic          w_lock_idx;
    logic          w_own_req;
    logic          w_own_lock;
    logic [CW-1:0] w_cnt_inc;
    logic          w_release;
    logic [3:0]    w_ram_we;
    logic [AW-1:0] w_ram_addr;
    logic [31:0]   w_ram_wdata;

    rr_pick2 u_pick (
        .i_req (bus.rq_req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick)
    );

    // Owner-of-lock view used by both the grant and the release decision
    assign w_lock_idx = (r_state == ST_LOCK1);
    assign w_own_req  = bus.rq_req[w_lock_idx];
    assign w_own_lock = bus.rq_lock[w_lock_idx];
    assign w_cnt_inc  = r_cnt + CW'(1);
    assign w_release  = !w_own_req || !w_own_lock || (w_cnt_inc >= MAX_CNT);

    // Grant: round-robin in ARB, owner-only while locked, nothing during reset
    always_comb begin
        w_gnt = 2'b00;
        case (r_state)
            ST_ARB:   w_gnt = w_pick;
            ST_LOCK0: w_gnt = {1'b0, bus.rq_req[REQ_CORE]};
            ST_LOCK1: w_gnt = {bus.rq_req[REQ_LOADER], 1'b0};
            default:  w_gnt = 2'b00;
        endcase
        if (!resetn) begin
            w_gnt = 2'b00;
        end
    end

    // RAM port follows the granted requester; idle port never writes
    always_comb begin
        w_ram_we    = 4'b0000;
        w_ram_addr  = bus.rq_addr0;
        w_ram_wdata = bus.rq_wdata0;
        if (w_gnt[REQ_LOADER]) begin
            w_ram_we    = bus.rq_we1;
            w_ram_addr  = bus.rq_addr1;
            w_ram_wdata = bus.rq_wdata1;
        end else if (w_gnt[REQ_CORE]) begin
            w_ram_we    = bus.rq_we0;
        end
    end

    // Arbitration FSM with round-robin pointer and burst counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_ARB;
            r_ptr   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (|w_gnt) begin
                        r_ptr <= other_req(w_gnt[REQ_LOADER]);
                        if (LOCK_EN && w_gnt[REQ_CORE] && bus.rq_lock[REQ_CORE]) begin
                            r_state <= ST_LOCK0;
                            r_cnt   <= CW'(1);
                        end else if (LOCK_EN && w_gnt[REQ_LOADER] && bus.rq_lock[REQ_LOADER]) begin
                            r_state <= ST_LOCK1;
                            r_cnt   <= CW'(1);
                        end
                    end
                end
                ST_LOCK0, ST_LOCK1: begin
                    // Leaving hands priority to the other side so a capped burst
                    // cannot immediately re-lock over a waiting requester
                    if (w_release) begin
                        r_state <= ST_ARB;
                        r_ptr   <= other_req(w_lock_idx);
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= ST_ARB;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Read-return tag: the RAM answers one cycle after an accepted read
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rvalid <= 2'b00;
        end else begin
            r_rvalid[REQ_CORE]   <= w_gnt[REQ_CORE]   && (bus.rq_we0 == 4'b0000);
            r_rvalid[REQ_LOADER] <= w_gnt[REQ_LOADER] && (bus.rq_we1 == 4'b0000);
        end
    end

    assign bus.rq_gnt    = w_gnt;
    assign bus.rq_rvalid = r_rvalid;
    assign bus.rq_rdata  = (|r_rvalid) ? bus.ram_rdata : 32'h0;
    assign bus.ram_en    = |w_gnt;
    assign bus.ram_we    = w_ram_we;
    assign bus.ram_addr  = w_ram_addr;
    assign bus.ram_wdata = w_ram_wdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Purpose: directed self-checking bench for ram_arbiter with a behavioural RAM.
// Latency: inputs driven at negedge, outputs sampled 1 time unit later.
// Backpressure: n/a.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int AW = 13;

    logic clk = 1'b0;
    logic resetn;
    int   n_chk  = 0;
    int   n_fail = 0;

    ram_arbiter_if #(.AW(AW)) bus();

    ram_arbiter #(.AW(AW), .MAX_LOCK(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM with byte enables, one-cycle read
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we == 4'b0000) begin
                bus.ram_rdata <= mem[bus.ram_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] lock,
                         input logic [3:0] we0, input logic [AW-1:0] a0, input logic [31:0] d0,
                         input logic [3:0] we1, input logic [AW-1:0] a1);
        bus.rq_req    = req;
        bus.rq_lock   = lock;
        bus.rq_we0    = we0;
        bus.rq_addr0  = a0;
        bus.rq_wdata0 = d0;
        bus.rq_we1    = we1;
        bus.rq_addr1  = a1;
        bus.rq_wdata1 = 32'hCAFE_0001;
    endtask

    logic [1:0] exp_g;
    logic [1:0] prev_g;
    int         n0, n1, n_lock;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        mem[3]  = 32'h1122_3344;
        mem[5]  = 32'hDEAD_BEEF;
        mem[16] = 32'hA0A0_0016;
        mem[17] = 32'hB1B1_0017;
        bus.ram_rdata = 32'h0;

        // Reset with both requesting: nothing granted, outputs quiet
        resetn = 1'b0;
        drive(2'b11, 2'b00, 4'h0, 13'd5, 32'h0, 4'h0, 13'd17);
        @(negedge clk); #1;
        chk("rst_gnt",    bus.rq_gnt,    2'b00);
        chk("rst_rvalid", bus.rq_rvalid, 2'b00);
        chk("rst_rdata",  bus.rq_rdata,  32'h0);
        chk("rst_ram_en", bus.ram_en,    1'b0);
        chk("rst_ram_we", bus.ram_we,    4'h0);
        @(negedge clk);
        resetn = 1'b1;
        drive(2'b00, 2'b00, 4'h0, 13'd0, 32'h0, 4'h0, 13'd0);
        #1 chk("idle_gnt", bus.rq_gnt, 2'b00);

        // Continuous reads from both: alternate 01,10,... with gapless rvalid
        n0 = 0; n1 = 0; prev_g = 2'b00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(2'b11, 2'b00, 4'h0, 13'd16, 32'h0, 4'h0, 13'd17);
            #1;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            chk("rr_gnt", bus.rq_gnt, exp_g);
            if (i > 0) begin
                chk("rr_rvalid", bus.rq_rvalid, prev_g);
                chk("rr_rdata",  bus.rq_rdata, (prev_g == 2'b01) ? 32'hA0A0_0016 : 32'hB1B1_0017);
            end
            n0 += int'(bus.rq_gnt[0]);
            n1 += int'(bus.rq_gnt[1]);
            prev_g = exp_g;
        end
        @(negedge clk);
        drive(2'b00, 2'b00, 4'h0, 13'd0, 32'h0, 4'h0, 13'd0);
        #1;
        chk("rr_last_rvalid", bus.rq_rvalid, 2'b10);
        chk("rr_last_rdata",  bus.rq_rdata,  32'hB1B1_0017);
        chk("rr_count0", n0, 4);
        chk("rr_count1", n1, 4);

        // Sole read by the core port from addr 5
        @(negedge clk);
        drive(2'b01, 2'b00, 4'h0, 13'd5, 32'h0, 4'h0, 13'd0);
        #1;
        chk("rd_gnt",      bus.rq_gnt,   2'b01);
        chk("rd_ram_en",   bus.ram_en,   1'b1);
        chk("rd_ram_addr", bus.ram_addr, 13'd5);
        chk("rd_ram_we",   bus.ram_we,   4'h0);
        @(negedge clk);
        drive(2'b00, 2'b00, 4'h0, 13'd0, 32'h0, 4'h0, 13'd0);
        #1;
        chk("rd_rvalid", bus.rq_rvalid, 2'b01);
        chk("rd_rdata",  bus.rq_rdata,  32'hDEAD_BEEF);
        chk("rd_gnt_off", bus.rq_gnt,   2'b00);

        // Byte write by port 0, then read of the same word by port 1
        @(negedge clk);
        drive(2'b01, 2'b00, 4'h1, 13'd3, 32'h0000_00A5, 4'h0, 13'd0);
        #1;
        chk("wr_gnt",       bus.rq_gnt,    2'b01);
        chk("wr_ram_we",    bus.ram_we,    4'h1);
        chk("wr_ram_wdata", bus.ram_wdata, 32'h0000_00A5);
        @(negedge clk);
        drive(2'b10, 2'b00, 4'h0, 13'd0, 32'h0, 4'h0, 13'd3);
        #1;
        chk("wr_rd_gnt",    bus.rq_gnt,    2'b10);
        chk("wr_no_rvalid", bus.rq_rvalid, 2'b00);
        @(negedge clk);
        drive(2'b00, 2'b00, 4'h0, 13'd0, 32'h0, 4'h0, 13'd0);
        #1;
        chk("wr_rd_rvalid", bus.rq_rvalid, 2'b10);
        chk("wr_rd_rdata",  bus.rq_rdata,  32'h1122_33A5);

        // Lock dropped on the third access: back to ARB, pointer favours port 0
        @(negedge clk);
        drive(2'b10, 2'b10, 4'h0, 13'd20, 32'h0, 4'hF, 13'd21);
        #1 chk("ld_gnt_a", bus.rq_gnt, 2'b10);
        @(negedge clk);
        drive(2'b11, 2'b10, 4'hF, 13'd20, 32'h0, 4'hF, 13'd21);
        #1 chk("ld_gnt_b", bus.rq_gnt, 2'b10);
        @(negedge clk);
        drive(2'b11, 2'b00, 4'hF, 13'd20, 32'h0, 4'hF, 13'd21);
        #1 chk("ld_gnt_c", bus.rq_gnt, 2'b10);
        @(negedge clk);
        #1 chk("ld_gnt_d", bus.rq_gnt, 2'b01);
        @(negedge clk);
        #1 chk("ld_gnt_e", bus.rq_gnt, 2'b10);

        // Pointer to port 1, then port 1 locks against a waiting port 0
        @(negedge clk);
        drive(2'b01, 2'b00, 4'hF, 13'd20, 32'h0, 4'hF, 13'd21);
        #1 chk("ml_setup_gnt", bus.rq_gnt, 2'b01);
        n_lock = 0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(2'b11, 2'b10, 4'hF, 13'd20, 32'h0, 4'hF, 13'd21);
            #1;
            chk("ml_gnt", bus.rq_gnt, (i < 16) ? 2'b10 : 2'b01);
            if (bus.rq_gnt == 2'b10) n_lock++;
        end
        chk("ml_burst_len", n_lock, 16);
        @(negedge clk);
        #1 chk("ml_relock_gnt", bus.rq_gnt, 2'b10);
        @(negedge clk);
        drive(2'b00, 2'b00, 4'h0, 13'd0, 32'h0, 4'h0, 13'd0);
        #1 chk("ml_drop_gnt", bus.rq_gnt, 2'b00);

        // Lock by the losing requester has no effect until it wins
        @(negedge clk);
        drive(2'b11, 2'b10, 4'hF, 13'd20, 32'h0, 4'hF, 13'd21);
        #1 chk("sl_gnt_a", bus.rq_gnt, 2'b01);
        @(negedge clk);
        #1 chk("sl_gnt_b", bus.rq_gnt, 2'b10);
        @(negedge clk);
        drive(2'b11, 2'b00, 4'hF, 13'd20, 32'h0, 4'hF, 13'd21);
        #1 chk("sl_gnt_c", bus.rq_gnt, 2'b10);
        @(negedge clk);
        drive(2'b00, 2'b00, 4'h0, 13'd0, 32'h0, 4'h0, 13'd0);

        // Reset pulse after an accepted read: read is dropped, pointer back to 0
        @(negedge clk);
        drive(2'b01, 2'b00, 4'h0, 13'd5, 32'h0, 4'h0, 13'd17);
        #1 chk("rp_gnt", bus.rq_gnt, 2'b01);
        @(negedge clk);
        resetn = 1'b0;
        drive(2'b11, 2'b00, 4'h0, 13'd5, 32'h0, 4'h0, 13'd17);
        #1;
        chk("rp_rvalid_in_rst", bus.rq_rvalid, 2'b00);
        chk("rp_gnt_in_rst",    bus.rq_gnt,    2'b00);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rp_rvalid_after", bus.rq_rvalid, 2'b00);
        chk("rp_first_gnt",    bus.rq_gnt,    2'b01);

        // Reset while locked to port 1 returns the FSM to ARB
        @(negedge clk);
        drive(2'b10, 2'b10, 4'h0, 13'd5, 32'h0, 4'h0, 13'd17);
        #1 chk("rl_gnt", bus.rq_gnt, 2'b10);
        @(negedge clk);
        resetn = 1'b0;
        drive(2'b00, 2'b00, 4'h0, 13'd5, 32'h0, 4'h0, 13'd17);
        #1 chk("rl_rvalid_in_rst", bus.rq_rvalid, 2'b00);
        @(negedge clk);
        resetn = 1'b1;
        drive(2'b11, 2'b00, 4'h0, 13'd5, 32'h0, 4'h0, 13'd17);
        #1 chk("rl_first_gnt", bus.rq_gnt, 2'b01);

        @(negedge clk);
        drive(2'b00, 2'b00, 4'h0, 13'd0, 32'h0, 4'h0, 13'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
